riscv_dmem_access: RTL and testbench

RISCV_DMEM_ACCESS -- requirements
Module: riscv_dmem_access

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/riscv_load_ext.sv | 25 ++
 rtl/riscv_dmem_access.sv | 124 ++++++++++++
 tb/tb_riscv_dmem_access.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory path: load extension types, store
// byte-enable widths and the access FSM states.
package riscv_pkg;

  localparam logic [2:0] DMEXT_LB  = 3'b001;
  localparam logic [2:0] DMEXT_LH  = 3'b010;
  localparam logic [2:0] DMEXT_LW  = 3'b011;
  localparam logic [2:0] DMEXT_LBU = 3'b100;
  localparam logic [2:0] DMEXT_LHU = 3'b101;

  localparam logic [3:0] WRBE_SB = 4'b0001;
  localparam logic [3:0] WRBE_SH = 4'b0011;
  localparam logic [3:0] WRBE_SW = 4'b1111;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_REQ  = 2'd1,
    DM_DONE = 2'd2,
    DM_ERR  = 2'd3
  } dmem_state_t;

  // True when the request cannot go to the bus. An unrecognised store width
  // is rejected outright; an unrecognised load type is aligned like a word.
  function automatic logic dmem_misaligned(input logic       we,
                                           input logic [1:0] off,
                                           input logic [3:0] wrbe,
                                           input logic [2:0] extop);
    logic bad;
    bad = 1'b0;
    if (we) begin
      case (wrbe)
        WRBE_SB: bad = 1'b0;
        WRBE_SH: bad = off[0];
        WRBE_SW: bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (extop)
        DMEXT_LB, DMEXT_LBU: bad = 1'b0;
        DMEXT_LH, DMEXT_LHU: bad = off[0];
        default:             bad = (off != 2'b00);
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Selects the addressed byte/halfword of a bus word and extends it to 32 bits.
module riscv_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  DMEXTop,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Right-align the addressed lane, then extend by load type.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (DMEXTop)
      DMEXT_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      DMEXT_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      DMEXT_LBU: result = {24'h0, shifted[7:0]};
      DMEXT_LHU: result = {16'h0, shifted[15:0]};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_access.sv
// Data-memory access sequencer between the control unit and a req/ack bus.
//
// state   | meaning
// --------+------------------------------------------------------------
// DM_IDLE | waiting for DMWr/DMRd; request fields are latched on accept
// DM_REQ  | bus_req high, waiting for bus_ack or the wait counter to expire
// DM_DONE | one-cycle done pulse, load data already registered
// DM_ERR  | one-cycle fault pulse (misaligned, bad width, or timeout)
//
// TIMEOUT must be at least 1; it is the number of REQ cycles allowed.
module riscv_dmem_access
  import riscv_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  WRbe,
  input  logic [2:0]  DMEXTop,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state, state_nxt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wrbe_q;
  logic [2:0]  extop_q;
  logic [7:0]  wait_cnt;
  logic        req_any;
  logic        accept;
  logic [31:0] load_val;

  assign req_any = DMWr | DMRd;
  assign accept  = (state == DM_IDLE) & req_any;

  riscv_load_ext u_load_ext (
    .word    (bus_rdata),
    .offset  (addr_q[1:0]),
    .DMEXTop (extop_q),
    .result  (load_val)
  );

  // State register; reset drops straight back to idle, aborting any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DM_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: DMWr takes priority when both requests are present.
  always_comb begin
    state_nxt = state;
    case (state)
      DM_IDLE: begin
        if (req_any) begin
          if (dmem_misaligned(DMWr, addr[1:0], WRbe, DMEXTop)) state_nxt = DM_ERR;
          else                                                 state_nxt = DM_REQ;
        end
      end
      DM_REQ: begin
        if (bus_ack)              state_nxt = DM_DONE;
        else if (wait_cnt == 8'd0) state_nxt = DM_ERR;
      end
      DM_DONE: state_nxt = DM_IDLE;
      DM_ERR:  state_nxt = DM_IDLE;
      default: state_nxt = DM_IDLE;
    endcase
  end

  // Request fields are captured once so bus outputs hold steady during REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wrbe_q  <= 4'h0;
      extop_q <= 3'h0;
    end else if (accept) begin
      we_q    <= DMWr;
      addr_q  <= addr;
      wdata_q <= wdata;
      wrbe_q  <= WRbe;
      extop_q <= DMEXTop;
    end
  end

  // Down-counter of remaining REQ cycles; zero with no ack means timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        wait_cnt <= 8'd0;
    else if (accept)                                 wait_cnt <= TIMEOUT - 8'd1;
    else if (state == DM_REQ && wait_cnt != 8'd0)    wait_cnt <= wait_cnt - 8'd1;
  end

  // Load result is registered on the ack edge and held until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      rdata <= 32'h0;
    else if (state == DM_REQ && bus_ack && !we_q)  rdata <= load_val;
  end

  assign bus_req   = (state == DM_REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = bus_req ? (we_q ? (wrbe_q << addr_q[1:0]) : 4'b1111) : 4'b0000;
  assign bus_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign done      = (state == DM_DONE);
  assign fault     = (state == DM_ERR);
  assign busy      = bus_req | ((state == DM_IDLE) & req_any & rst);

endmodule

// File: tb/tb_riscv_dmem_access.sv
module tb_riscv_dmem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMWr, DMRd;
  logic [31:0] addr, wdata;
  logic [3:0]  WRbe;
  logic [2:0]  DMEXTop;
  logic [31:0] rdata;
  logic        busy, done, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  riscv_dmem_access #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .DMWr(DMWr), .DMRd(DMRd), .addr(addr), .wdata(wdata),
    .WRbe(WRbe), .DMEXTop(DMEXTop), .rdata(rdata), .busy(busy), .done(done),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: can this request legally reach the bus?
  function automatic bit m_bad(bit st, logic [31:0] a, logic [3:0] be, logic [2:0] op);
    int off = int'(a % 4);
    if (st) begin
      if (be == 4'd1)  return 0;
      if (be == 4'd3)  return (off % 2) != 0;
      if (be == 4'd15) return off != 0;
      return 1;
    end
    if (op == 3'd1 || op == 3'd4) return 0;
    if (op == 3'd2 || op == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  // Reference: value the load returns for bus word w at byte address a.
  function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [2:0] op);
    longint unsigned sh;
    longint v;
    sh = longint'(w) / (longint'(1) << (8 * (a % 4)));
    case (op)
      3'd1: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
      3'd2: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = sh % 256;
      3'd5: v = sh % 65536;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // One complete access, starting and ending at a negedge with the DUT idle.
  task automatic access(input bit st, input bit both, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [2:0] op,
                        input int waits, input logic [31:0] brd, input string tag);
    bit bad;
    longint unsigned wprod;
    logic [31:0] e_be, e_wd, e_rd;
    int off;
    off   = int'(a % 4);
    bad   = m_bad(st, a, be, op);
    e_be  = st ? ((32'(be) * (32'd1 << off)) % 16) : 32'd15;
    wprod = (longint'(wd) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
    e_wd  = wprod[31:0];
    e_rd  = m_load(brd, a, op);
    DMWr = st; DMRd = !st || both; addr = a; wdata = wd; WRbe = be; DMEXTop = op;
    #1;
    if (!bad) check({tag, "_busy_idle"}, busy, 1);
    @(negedge clk);
    DMWr = 0; DMRd = 0; addr = $urandom; wdata = $urandom; WRbe = 4'($urandom); DMEXTop = 3'($urandom);
    if (bad) begin
      check({tag, "_fault"}, fault, 1);
      check({tag, "_err_bus_req"}, bus_req, 0);
      check({tag, "_err_done"}, done, 0);
      @(negedge clk);
      check({tag, "_fault_pulse"}, fault, 0);
      check({tag, "_err_bus_req2"}, bus_req, 0);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_bus_req"}, bus_req, 1);
      check({tag, "_bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
      check({tag, "_bus_be"}, bus_be, e_be);
      check({tag, "_bus_we"}, bus_we, st);
      if (st) check({tag, "_bus_wdata"}, bus_wdata, e_wd);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_early"}, done, 0);
      if (i == waits) begin
        bus_ack = 1; bus_rdata = brd; DMRd = 0; DMWr = 0;
      end else begin
        DMRd = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bus_ack = 0; bus_rdata = $urandom; DMRd = 0; DMWr = 0;
    check({tag, "_done"}, done, 1);
    check({tag, "_no_fault"}, fault, 0);
    check({tag, "_req_off"}, bus_req, 0);
    if (!st) check({tag, "_rdata"}, rdata, e_rd);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_req"}, bus_req, 0);
    if (!st) check({tag, "_rdata_hold"}, rdata, e_rd);
  endtask

  initial begin
    rst = 0; DMWr = 0; DMRd = 0; addr = 0; wdata = 0; WRbe = 0; DMEXTop = 0;
    bus_ack = 0; bus_rdata = 0;
    #12;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done_fault", {done, fault}, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    access(1, 0, 32'h1003, 32'hAB, 4'b0001, 3'd0, 2, 32'h0, "sb");
    access(0, 0, 32'h2001, 32'h0, 4'h0, 3'd1, 0, 32'h0000F400, "lb");
    access(0, 0, 32'h2001, 32'h0, 4'h0, 3'd4, 1, 32'h0000F400, "lbu");
    access(0, 0, 32'h3001, 32'h0, 4'h0, 3'd2, 0, 32'h0, "lh_mis");
    access(0, 0, 32'h3004, 32'h0, 4'h0, 3'd3, 0, 32'h89AB_CDEF, "lw_after");
    access(1, 1, 32'h4002, 32'h1234, 4'b0011, 3'd3, 1, 32'h0, "both");
    access(1, 0, 32'h5000, 32'h55, 4'b0101, 3'd3, 0, 32'h0, "bad_be");
    access(0, 0, 32'h6002, 32'h0, 4'h0, 3'd7, 0, 32'h0, "unk_op_mis");

    // Timeout: no ack ever, TIMEOUT=4.
    DMRd = 1; addr = 32'h40; DMEXTop = 3'd3;
    @(negedge clk);
    DMRd = 0;
    for (int k = 1; k <= 4; k++) begin
      check("to_wait_fault", fault, 0);
      check("to_wait_req", bus_req, 1);
      @(negedge clk);
    end
    check("to_fault", fault, 1);
    check("to_no_done", done, 0);
    @(negedge clk);
    check("to_fault_pulse", fault, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [3:0]  be;
      int r;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 3);
      be = (r == 0) ? 4'd1 : (r == 1) ? 4'd3 : (r == 2) ? 4'd15 : 4'($urandom);
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, be,
             3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom, "rnd");
    end

    // Reset in the middle of a load.
    DMRd = 1; addr = 32'h80; DMEXTop = 3'd3;
    @(negedge clk);
    DMRd = 0;
    check("mid_req_up", bus_req, 1);
    #2 rst = 0;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_bus_be", bus_be, 0);
    check("mid_rst_bus_we", bus_we, 0);
    check("mid_rst_bus_addr", bus_addr, 0);
    check("mid_rst_bus_wdata", bus_wdata, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done_fault", {done, fault}, 0);
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_done_fault", {done, fault}, 0);
      check("post_rst_bus_req", bus_req, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
